// File: rtl/redgate_pipe.sv
// Pipelined 4-ary reduction tree (AND/OR/NAND/NOR/XOR/XNOR/buffer) with
// valid/ready flow control and a saturating count of delivered ones.
module redgate_pipe #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_din,
  input  logic [2:0]       i_op,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_q,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_ones_cnt
);

  typedef enum logic [1:0] {CLS_AND, CLS_OR, CLS_XOR} cls_e;

  // Number of partials left after k levels of 4:1 reduction.
  function automatic int lvl_n(input int k);
    int n;
    n = WIDTH;
    for (int i = 0; i < k; i++) n = (n + 3) / 4;
    return n;
  endfunction

  function automatic int calc_lat();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 1) begin
      n = (n + 3) / 4;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LAT = calc_lat();

  function automatic cls_e op_cls(input logic [2:0] op);
    case (op)
      3'd0, 3'd2: return CLS_AND;
      3'd4, 3'd5: return CLS_XOR;
      default:    return CLS_OR;
    endcase
  endfunction

  function automatic logic op_inv(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
  endfunction

  function automatic logic red4(input logic [3:0] g, input cls_e c);
    case (c)
      CLS_AND: return &g;
      CLS_OR:  return |g;
      default: return ^g;
    endcase
  endfunction

  logic             w_adv;
  logic [LAT-1:0]   r_vld;
  logic [LAT-1:0]   w_vld;
  logic [2:0]       r_op   [LAT];
  logic [2:0]       w_op   [LAT];
  logic [WIDTH-1:0] r_part [LAT];
  logic [WIDTH-1:0] w_part [LAT];
  logic [CNT_W-1:0] r_cnt;

  assign w_adv       = !o_out_valid || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_vld[LAT-1];
  assign o_q         = r_part[LAT-1][0];
  assign o_ones_cnt  = r_cnt;

  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int N_IN  = lvl_n(k);
    localparam int N_OUT = lvl_n(k + 1);
    logic [N_IN-1:0]  w_src;
    logic [WIDTH-1:0] w_out;
    cls_e             w_cls;
    logic             w_inv;

    if (k == 0) begin : g_first
      assign w_op[k]  = i_op;
      assign w_vld[k] = i_in_valid;
      // Buffer ops keep only DIN[0] and OR-reduce, so later levels need no special case.
      assign w_src = (i_op[2:1] == 2'b11) ? {{(N_IN-1){1'b0}}, i_din[0]} : i_din;
    end else begin : g_next
      assign w_op[k]  = r_op[k-1];
      assign w_vld[k] = r_vld[k-1];
      assign w_src    = r_part[k-1][N_IN-1:0];
    end

    assign w_cls = op_cls(w_op[k]);

    if (k == LAT - 1) begin : g_last
      assign w_inv = op_inv(w_op[k]);
    end else begin : g_mid
      assign w_inv = 1'b0;
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_grp
      logic [3:0] w_grp;
      for (genvar j = 0; j < 4; j++) begin : g_bit
        if (4 * g + j < N_IN) begin : g_data
          assign w_grp[j] = w_src[4*g+j];
        end else begin : g_pad
          assign w_grp[j] = (w_cls == CLS_AND);
        end
      end
      assign w_out[g] = red4(w_grp, w_cls) ^ w_inv;
    end

    if (N_OUT < WIDTH) begin : g_zero
      assign w_out[WIDTH-1:N_OUT] = '0;
    end

    assign w_part[k] = w_out;
  end

  // NOTE: sequential state uses non-blocking assignments so every level samples
  // the previous level's pre-edge value; blocking here would collapse the pipe.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_vld <= '0;
      // NOTE: clearing the datapath too keeps Q at 0 out of reset; it is
      // only a few flops, unlike a RAM which should never be reset.
      for (int k = 0; k < LAT; k++) begin
        r_op[k]   <= '0;
        r_part[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld <= w_vld;
      for (int k = 0; k < LAT; k++) begin
        r_op[k]   <= w_op[k];
        r_part[k] <= w_part[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_cnt_clr) begin
      r_cnt <= '0;
    end else if (o_out_valid && i_out_ready && o_q && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_redgate_pipe.sv
// Scoreboard bench for redgate_pipe: directed tests on a WIDTH=9/CNT_W=4 build,
// random traffic on WIDTH=2 and WIDTH=64 builds against a flat golden reduction.
module tb_redgate_pipe;

  logic       clk = 1'b0;
  logic       rstn;
  logic [8:0] din;
  logic [2:0] op;
  logic       in_valid, in_ready, q, out_valid, out_ready, cnt_clr;
  logic [3:0] cnt;

  logic [1:0]  d2_din;
  logic [63:0] d64_din;
  logic [2:0]  r_op;
  logic        r_v, r_rdy;
  logic        d2_irdy, d2_q, d2_ov, d64_irdy, d64_q, d64_ov;
  logic [15:0] d2_cnt, d64_cnt;
  logic        zero = 1'b0;

  int   checks = 0;
  int   failures = 0;
  int   n_pop = 0;
  int   m_cnt = 0;
  logic last_stall = 1'b0;
  logic last_q = 1'b0;
  logic sb9[$];
  logic q2[$];
  logic q64[$];

  always #5 clk = ~clk;

  redgate_pipe #(.WIDTH(9), .CNT_W(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_din(din), .i_op(op), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .o_q(q), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .i_cnt_clr(cnt_clr), .o_ones_cnt(cnt));

  redgate_pipe #(.WIDTH(2)) dut_w2 (
    .i_clk(clk), .i_rstn(rstn), .i_din(d2_din), .i_op(r_op), .i_in_valid(r_v),
    .o_in_ready(d2_irdy), .o_q(d2_q), .o_out_valid(d2_ov), .i_out_ready(r_rdy),
    .i_cnt_clr(zero), .o_ones_cnt(d2_cnt));

  redgate_pipe #(.WIDTH(64)) dut_w64 (
    .i_clk(clk), .i_rstn(rstn), .i_din(d64_din), .i_op(r_op), .i_in_valid(r_v),
    .o_in_ready(d64_irdy), .o_q(d64_q), .o_out_valid(d64_ov), .i_out_ready(r_rdy),
    .i_cnt_clr(zero), .o_ones_cnt(d64_cnt));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic gold(input logic [63:0] d, input int w, input logic [2:0] o);
    logic a, r, x;
    a = 1'b1; r = 1'b0; x = 1'b0;
    for (int i = 0; i < w; i++) begin
      a = a & d[i];
      r = r | d[i];
      x = x ^ d[i];
    end
    case (o)
      3'd0: return a;
      3'd1: return r;
      3'd2: return ~a;
      3'd3: return ~r;
      3'd4: return x;
      3'd5: return ~x;
      default: return d[0];
    endcase
  endfunction

  // One cycle on the WIDTH=9 instance, entered and left at a falling edge.
  task automatic step(input logic rst, input logic v, input logic [8:0] d, input logic [2:0] o,
                      input logic rdy, input logic clr, output logic acc);
    logic exp;
    rstn = rst; in_valid = v; din = d; op = o; out_ready = rdy; cnt_clr = clr;
    #1;
    acc = 1'b0;
    check("in_ready", in_ready, !out_valid || rdy);
    if (last_stall) check("q_hold", q, last_q);
    last_stall = rst && out_valid && !rdy;
    last_q = q;
    if (!rst) begin
      sb9.delete();
      m_cnt = 0;
    end else begin
      if (out_valid && rdy) begin
        if (sb9.size() == 0) begin
          check("stale_out", out_valid, 0);
        end else begin
          exp = sb9.pop_front();
          check("q", q, exp);
          n_pop++;
          if (exp && m_cnt < 15) m_cnt++;
        end
      end
      if (clr) m_cnt = 0;
      if (v && in_ready) begin
        sb9.push_back(gold(d, 9, o));
        acc = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("ones_cnt", cnt, m_cnt);
  endtask

  // One cycle of random stimulus on the WIDTH=2 and WIDTH=64 instances.
  task automatic rstep(input logic v, input logic rdy);
    logic [63:0] d;
    logic [2:0]  o;
    d = {$urandom, $urandom};
    o = 3'($urandom_range(0, 7));
    d2_din = d[1:0]; d64_din = d; r_op = o; r_v = v; r_rdy = rdy;
    #1;
    if (d2_ov && rdy) begin
      if (q2.size() == 0) check("w2_stale", d2_ov, 0);
      else check("w2_q", d2_q, q2.pop_front());
    end
    if (d64_ov && rdy) begin
      if (q64.size() == 0) check("w64_stale", d64_ov, 0);
      else check("w64_q", d64_q, q64.pop_front());
    end
    if (v && d2_irdy) q2.push_back(gold(d, 2, o));
    if (v && d64_irdy) q64.push_back(gold(d, 64, o));
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [8:0] d;
    logic [2:0] o;
  } item_t;

  initial begin
    logic  acc;
    int    n0, ptr, lat2, lat64;
    item_t items[3];

    d2_din = '0; d64_din = '0; r_op = '0; r_v = 1'b0; r_rdy = 1'b1;

    // Reset with a transfer offered: it must be discarded.
    step(0, 1, 9'h1FF, 3'd0, 1, 0, acc);
    step(0, 1, 9'h1FF, 3'd0, 1, 0, acc);
    check("rst_ov", out_valid, 0);
    check("rst_q", q, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("discard", out_valid, 0);

    // Single AND of all-ones: valid exactly two cycles later.
    step(1, 1, 9'h1FF, 3'd0, 1, 0, acc);
    check("lat_pre", out_valid, 0);
    step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("lat_vld", out_valid, 1);
    check("lat_q", q, 1);
    step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("cnt_one", cnt, 1);

    // Back-to-back with changing ops, including buffer ops.
    n0 = n_pop;
    step(1, 1, 9'h001, 3'd4, 1, 0, acc);
    step(1, 1, 9'h003, 3'd4, 1, 0, acc);
    step(1, 1, 9'h100, 3'd4, 1, 0, acc);
    step(1, 1, 9'h000, 3'd3, 1, 0, acc);
    step(1, 1, 9'h1FE, 3'd6, 1, 0, acc);
    step(1, 1, 9'h001, 3'd7, 1, 0, acc);
    step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("thru", n_pop - n0, 6);

    // Stall: consumer blocks for 5 cycles while 3 operands are offered.
    items[0] = '{9'h1FF, 3'd0};
    items[1] = '{9'h000, 3'd1};
    items[2] = '{9'h000, 3'd5};
    n0 = n_pop;
    ptr = 0;
    for (int c = 0; c < 14; c++) begin
      if (c == 4) check("full_rdy", in_ready, 0);
      step(1, ptr < 3, items[ptr % 3].d, items[ptr % 3].o, c >= 5, 0, acc);
      if (acc) ptr++;
    end
    check("stall_cnt", n_pop - n0, 3);

    // Saturation at 15, then clear colliding with an increment.
    step(1, 0, 9'h0, 3'd0, 1, 1, acc);
    for (int i = 0; i < 17; i++) step(1, 1, 9'h1FF, 3'd0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("cnt_sat", cnt, 15);
    step(1, 1, 9'h1FF, 3'd0, 1, 1, acc);
    step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("clr_ov", out_valid, 1);
    step(1, 0, 9'h0, 3'd0, 1, 1, acc);
    check("clr_prio", cnt, 0);

    // Reset with two results in flight: none may ever surface.
    step(1, 1, 9'h1FF, 3'd0, 0, 0, acc);
    step(1, 1, 9'h1FF, 3'd0, 0, 0, acc);
    step(0, 0, 9'h0, 3'd0, 0, 0, acc);
    check("mid_rst_ov", out_valid, 0);
    n0 = n_pop;
    for (int i = 0; i < 3; i++) step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    step(1, 1, 9'h000, 3'd0, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(1, 0, 9'h0, 3'd0, 1, 0, acc);
    check("post_rst", n_pop - n0, 1);

    // WIDTH=2 / WIDTH=64: latency, then random traffic and drain.
    rstep(1, 1);
    lat2 = 0;
    lat64 = 0;
    for (int n = 1; n <= 8; n++) begin
      if (lat2 == 0 && d2_ov) lat2 = n;
      if (lat64 == 0 && d64_ov) lat64 = n;
      rstep(0, 1);
    end
    check("w2_lat", lat2, 1);
    check("w64_lat", lat64, 3);
    for (int i = 0; i < 400; i++) rstep($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 20; i++) rstep(0, 1);
    check("w2_drain", q2.size(), 0);
    check("w64_drain", q64.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redgate_pipe.md
REDGATE_PIPE -- requirements
Module: redgate_pipe

Interface
REQ-001 Parameter WIDTH, default 9, number of data inputs reduced, legal range 2..64.
REQ-002 Parameter CNT_W, default 16, width of the result-ones counter.
REQ-003 Derived constant LAT = ceil(log4(WIDTH)), minimum 1, which is the number of register levels.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RSTN  input  1  reset, synchronous, active-low.
REQ-006 DIN  input  WIDTH  operand vector.
REQ-007 OP  input  3  operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 buffer of DIN[0].
REQ-008 IN_VALID  input  1  DIN/OP valid this cycle.
REQ-009 IN_READY  output  1  block accepts DIN/OP this cycle.
REQ-010 Q  output  1  reduction result.
REQ-011 OUT_VALID  output  1  Q valid.
REQ-012 OUT_READY  input  1  consumer accepts Q.
REQ-013 CNT_CLR  input  1  synchronous clear of ONES_CNT.
REQ-014 ONES_CNT  output  CNT_W  count of delivered results equal to 1.

Function
REQ-015 Transfer in = IN_VALID & IN_READY; transfer out = OUT_VALID & OUT_READY.
REQ-016 Advance signal ADV = !OUT_VALID | OUT_READY; IN_READY SHALL equal ADV combinationally.
REQ-017 When ADV=1, every pipeline level, including its valid bit, SHALL shift one level; when ADV=0, all levels SHALL hold.
REQ-018 Level 1 SHALL reduce DIN in groups of 4 bits, lowest bits first; a final partial group SHALL be padded with the identity value: 1 for AND-class ops, 0 for OR/XOR-class ops.
REQ-019 Each subsequent level SHALL reduce the previous level's partials in groups of 4 until one bit remains.
REQ-020 OP SHALL be registered alongside the data at every level; an OP change while data is in flight SHALL NOT affect earlier accepted operands.
REQ-021 Inversion for NAND/NOR/XNOR SHALL be applied only at the final level; Q SHALL be a registered output.
REQ-022 Latency from transfer-in to OUT_VALID SHALL be exactly LAT cycles when there is no stall; throughput SHALL be 1 result per cycle.
REQ-023 Results SHALL emerge in acceptance order with no loss or duplication under any OUT_READY pattern.
REQ-024 A cycle with IN_VALID=0 and ADV=1 SHALL insert a bubble, i.e. a valid bit of 0.
REQ-025 Q SHALL hold its value while OUT_VALID=1 and OUT_READY=0.
REQ-026 ONES_CNT SHALL increment by 1 on each transfer-out with Q=1 and SHALL saturate at all-ones.
REQ-027 CNT_CLR has priority over an increment in the same cycle; the result SHALL be 0.
REQ-028 Behaviour with OP=6/7 SHALL equal the buffer of DIN[0], irrespective of other bits.

Reset
REQ-029 While RSTN=0 at a rising edge, the following SHALL be cleared: all valid bits, Q=0, OUT_VALID=0, ONES_CNT=0.
REQ-030 During reset, IN_READY SHALL be 1, since OUT_VALID=0; transfers presented during reset SHALL be discarded.
REQ-031 Reset asserted mid-stream SHALL drop all in-flight results; the first result after release SHALL come from the first operand accepted after release.

Verification
REQ-032 WIDTH=9, OP=0, DIN=9'h1FF, one cycle valid, OUT_READY=1 -> OUT_VALID=1, Q=1 exactly 2 cycles later; ONES_CNT=1.
REQ-033 WIDTH=9, back-to-back OP=4 with DIN=9'h001, 9'h003, 9'h100, then OP=3 with DIN=0 -> Q sequence 1,0,1,1 on consecutive cycles.
REQ-034 Stall test: OUT_READY=0 for 5 cycles while 3 operands are accepted -> IN_READY=0 once the pipe is full, Q held stable, and all 3 results delivered in order after release.
REQ-035 ONES_CNT with CNT_W=4: 17 results with Q=1 -> ONES_CNT=15 (saturates); CNT_CLR together with an increment -> 0.
REQ-036 RSTN=0 for 1 cycle with 2 results in flight -> OUT_VALID=0 next cycle; no stale result is ever delivered.
REQ-037 WIDTH=2 and WIDTH=64 builds: random OP/DIN against a golden reduction -> zero mismatches; latency is 1 and 3 respectively.
